color_sequencer: RTL
====================

// Module: color_sequencer
// PURPOSE
//  Parametrised successor to the single-colour show mapper: turns the pixel `show` bit into
//  RGB, with colour taken from a writable palette and sequenced at the FSM tick rate.
//  Sits between the display FSM (supplies show, fsm_tick) and the VGA DAC pins.
//  Modes: solid, cycle, blink, ping-pong.
// PARAMETERS
//  CHAN_W         4   bits per colour channel (red/green/blue each CHAN_W wide)
//  PALETTE_DEPTH  8   number of palette entries, >=1
//  IDX_W          3   palette index width, >= clog2(PALETTE_DEPTH), >=1
// PORTS
//  clock        in   1         single clock; all state on rising edge
//  reset_n      in   1         asynchronous, active-low reset
//  fsm_tick     in   1         1-cycle pulse at FSM rate; advances sequence
//  show         in   1         1 = pixel lit, 0 = black
//  mode         in   2         0 SOLID, 1 CYCLE, 2 BLINK, 3 PINGPONG
//  hold         in   1         1 = freeze sequence state (ticks ignored)
//  pal_we       in   1         palette write strobe
//  pal_addr     in   IDX_W     palette write address
//  pal_data     in   3*CHAN_W  {r,g,b} write data
//  red          out  CHAN_W    registered red
//  green        out  CHAN_W    registered green
//  blue         out  CHAN_W    registered blue
//  cur_index    out  IDX_W     palette entry currently selected
// BEHAVIOUR
//  - Reset (async assert, sync release): red/green/blue=0, cur_index=0, blink_phase=0,
//    dir=up, mode_q=0; every palette entry = all ones (white).
//  - Output latency 1 cycle: rgb(N+1) = show(N) & visible(N) ? palette[cur_index(N)] : 0.
//    visible = 0 only in BLINK with blink_phase=1; else 1.
//  - Sequence state updates only on fsm_tick=1 & hold=0 & mode unchanged (mode==mode_q):
//    SOLID: cur_index held at 0.
//    CYCLE: idx = (idx==PALETTE_DEPTH-1) ? 0 : idx+1.
//    BLINK: cur_index held at 0; blink_phase toggles.
//    PINGPONG: dir up: idx+1, at PALETTE_DEPTH-1 flip to down then decrement next;
//      dir down: idx-1, at 0 flip to up. Sequence 0,1,..,D-1,D-2,..,0,1,..; no end repeat.
//    PALETTE_DEPTH=1: idx stays 0 in every mode; no wrap arithmetic overflow.
//  - Mode change (mode != mode_q): next edge sets mode_q=mode, cur_index=0, blink_phase=0,
//    dir=up; a coincident fsm_tick is discarded.
//  - hold=1: ticks dropped (not queued); rgb still follows show and palette writes.
//  - show is not gating sequencing: sequence advances while show=0.
//  - Palette write: pal_we=1 & pal_addr<PALETTE_DEPTH writes entry at edge N; visible on rgb
//    at edge N+1 if selected. pal_addr>=PALETTE_DEPTH: write ignored, no side effects.
//    Write + tick same cycle: both take effect; rgb at N+1 uses old index, new data.
//  - Reset mid-sequence: immediate return to reset values; palette restored to white.
//  - All arithmetic on IDX_W bits; compares against PALETTE_DEPTH-1 sized to IDX_W.
// STRUCTURE
//  - Shared include color_defs.vh: mode encodings (MODE_SOLID/CYCLE/BLINK/PINGPONG),
//    palette reset value macro (all ones).
//  - Sub-module color_palette: PALETTE_DEPTH x 3*CHAN_W register file, async reset to white,
//    one write port with range check, one combinational read port.
//  - Top holds sequencer FSM (mode_q, cur_index, dir, blink_phase) and output registers.
// TESTING
//  1 Reset, mode=0, show=1 -> rgb=F,F,F one cycle after show; show=0 -> 0,0,0 next cycle.
//  2 D=8, write entries 0..7, mode=1, 9 ticks -> cur_index 1..7,0,1; rgb=palette[idx] each.
//  3 mode=3, D=4, 8 ticks -> cur_index 1,2,3,2,1,0,1,2; D=1 -> always 0.
//  4 mode=2, show=1, entry0=0xA5C -> rgb alternates A5C / 000 per tick; hold=1 freezes phase.
//  5 CYCLE at idx 5, mode->3 with tick same cycle -> idx=0, dir=up; tick dropped.
//  6 pal_we to addr 9 (D=8) -> no change; write to current idx + tick -> new data old idx;
//    reset_n low mid-CYCLE -> rgb=0, idx=0 immediately, palette white.

Source files
------------

// File: rtl/color_sequencer_pkg.sv
// color_sequencer_pkg: mode encodings shared by the colour sequencer and its bench
package color_sequencer_pkg;
    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_CYCLE    = 2'd1,
        MODE_BLINK    = 2'd2,
        MODE_PINGPONG = 2'd3
    } mode_e;
endpackage

// File: rtl/color_sequencer_palette.sv
// color_sequencer_palette: white-on-reset palette register file, one write port, write-through read
module color_sequencer_palette #(
    parameter int CHAN_W        = 4,
    parameter int PALETTE_DEPTH = 8,
    parameter int IDX_W         = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [3*CHAN_W-1:0] wdata,
    input  logic [IDX_W-1:0]    raddr,
    output logic [3*CHAN_W-1:0] rdata
);
    logic [3*CHAN_W-1:0] pal_q [PALETTE_DEPTH];
    logic [3*CHAN_W-1:0] pal_d [PALETTE_DEPTH];
    logic [3*CHAN_W-1:0] mem_rd;
    // only in-range addresses match an entry, so out-of-range writes fall through untouched
    always_comb begin
        pal_d  = pal_q;
        mem_rd = '0;
        for (int i = 0; i < PALETTE_DEPTH; i++) begin
            if (we && waddr == IDX_W'(i)) pal_d[i] = wdata;
            if (raddr == IDX_W'(i)) mem_rd = pal_q[i];
        end
        rdata = (we && waddr == raddr) ? wdata : mem_rd;
    end
    // entries come out of reset as white
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pal_q <= '{default: '1};
        else          pal_q <= pal_d;
    end
endmodule

// File: rtl/color_sequencer.sv
// color_sequencer: maps the show bit to palette RGB, sequencing the palette index on FSM ticks
module color_sequencer
    import color_sequencer_pkg::*;
#(
    parameter int CHAN_W        = 4,
    parameter int PALETTE_DEPTH = 8,
    parameter int IDX_W         = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                fsm_tick,
    input  logic                show,
    input  logic [1:0]          mode,
    input  logic                hold,
    input  logic                pal_we,
    input  logic [IDX_W-1:0]    pal_addr,
    input  logic [3*CHAN_W-1:0] pal_data,
    output logic [CHAN_W-1:0]   red,
    output logic [CHAN_W-1:0]   green,
    output logic [CHAN_W-1:0]   blue,
    output logic [IDX_W-1:0]    cur_index
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(PALETTE_DEPTH - 1);
    mode_e               mode_q, mode_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                dir_q, dir_d;
    logic                blink_q, blink_d;
    logic [3*CHAN_W-1:0] rgb_q, rgb_d;
    logic [3*CHAN_W-1:0] pal_rdata;
    logic                up_next;
    color_sequencer_palette #(
        .CHAN_W(CHAN_W),
        .PALETTE_DEPTH(PALETTE_DEPTH),
        .IDX_W(IDX_W)
    ) u_palette (
        .clock(clock),
        .reset_n(reset_n),
        .we(pal_we),
        .waddr(pal_addr),
        .wdata(pal_data),
        .raddr(idx_q),
        .rdata(pal_rdata)
    );
    // next sequence state; a mode change restarts the sequence and swallows any coincident tick
    always_comb begin
        mode_d  = mode_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        blink_d = blink_q;
        up_next = dir_q ? (idx_q == '0) : (idx_q != LAST);
        if (mode != mode_q) begin
            mode_d  = mode_e'(mode);
            idx_d   = '0;
            dir_d   = 1'b0;
            blink_d = 1'b0;
        end else if (fsm_tick && !hold) begin
            case (mode_q)
                MODE_CYCLE:    idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
                MODE_BLINK:    blink_d = ~blink_q;
                MODE_PINGPONG: begin
                    idx_d = (PALETTE_DEPTH == 1) ? '0 : up_next ? idx_q + 1'b1 : idx_q - 1'b1;
                    dir_d = ~up_next;
                end
                default:       idx_d = '0;
            endcase
        end
        rgb_d = (show && !(mode_q == MODE_BLINK && blink_q)) ? pal_rdata : '0;
    end
    // sequencer state and registered colour outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_SOLID;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            blink_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            blink_q <= blink_d;
            rgb_q   <= rgb_d;
        end
    end
    assign {red, green, blue} = rgb_q;
    assign cur_index          = idx_q;
endmodule
